vga_scan_timing: RTL and testbench
==================================

Name: vga_scan_timing

Overview:
- Drives the raster scan that the color mapper consumes.
- Generates DrawX/DrawY, registers the mapper's combinational RGB answer, and emits aligned VGA sync, blank and pixel-clock signals to the DAC.
- Provides a one-cycle frame_tick at the start of vertical blanking. Game logic (block/shape position updates) advances on that tick.
- Sits between the 50 MHz system clock domain and the VGA pins.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=2).
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch, pixels.
- H_SYNC, 96, hsync width, pixels.
- H_BP, 48, horizontal back porch, pixels.
- V_VISIBLE, 480, active lines.
- V_FP, 10, vertical front porch, lines.
- V_SYNC, 2, vsync width, lines.
- V_BP, 33, vertical back porch, lines.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- Red_in  in  8  red from color mapper for the current DrawX/DrawY.
- Green_in  in  8  green from color mapper.
- Blue_in  in  8  blue from color mapper.
- DrawX  out  10  current horizontal count.
- DrawY  out  10  current vertical count.
- VGA_R  out  8  registered red to DAC.
- VGA_G  out  8  registered green to DAC.
- VGA_B  out  8  registered blue to DAC.
- VGA_HS  out  1  hsync, active low.
- VGA_VS  out  1  vsync, active low.
- VGA_BLANK_N  out  1  low outside the visible region.
- VGA_SYNC_N  out  1  tied 0.
- VGA_CLK  out  1  pixel clock; high for the first CLK_DIV/2 cycles of each pixel period.
- frame_tick  out  1  one-Clk pulse at start of vertical blank.

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <=1024; width is 10 bits.
- Clock divider:
  - div counts 0..CLK_DIV-1 on Clk.
  - pix_en is asserted when div == CLK_DIV-1.
- Counters:
  - On pix_en, hc increments, wrapping from H_TOTAL-1 to 0.
  - On that wrap, vc increments, wrapping from V_TOTAL-1 to 0.
  - hc and vc hold between pix_en pulses.
- DrawX = hc and DrawY = vc, driven directly from the counter registers.
- DrawX/DrawY also expose blanking-region values (DrawX up to 799, DrawY up to 524). The mapper must tolerate these.
- Output stage, updated on pix_en only, one pixel of latency:
  - VGA_R/G/B <= visible ? *_in : 0. visible = (hc < H_VISIBLE && vc < V_VISIBLE).
  - VGA_BLANK_N <= visible.
  - VGA_HS <= !(hc in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]).
  - VGA_VS <= !(vc in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]).
  - Sync, blank and RGB therefore describe the same pixel in the same cycle.
- frame_tick:
  - Asserted for exactly one Clk cycle.
  - Fires on the pix_en where hc wraps to 0 and vc becomes V_VISIBLE.
  - This is the first blank line, once per frame.
- Reset values (asynchronous):
  - div=0, hc=0, vc=0.
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - frame_tick=0, VGA_CLK=0.
- Reset asserted mid-frame: all state clears immediately. After release, the scan restarts at (0,0) and the first pix_en occurs CLK_DIV cycles after release.
- Inputs sampled only on pix_en. Changes on *_in between pix_en pulses have no effect.
- No state machine beyond the counters. All wrap and sync comparisons are unsigned.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: Red_in/Green_in/Blue_in are ignored. The visible region shows 8 vertical bars, each H_VISIBLE/8 = 80 pixels wide. Bar index = DrawX[9:0]/80; bit0 drives Blue, bit1 Green, bit2 Red; each component is 8'hFF or 8'h00. Bar 0 is black, bar 7 is white.
- Blank, sync and frame_tick timing are identical with and without the macro.
- Undefined: mapper colors are passed through as described in Behaviour.

Test Plan:
- Reset release, run 2*800*525 pix_en -> exactly 2 frame_tick pulses; the first occurs when (DrawX,DrawY) becomes (0,480). VGA_VS is low for exactly 1600 pix_en (2 lines) per frame.
- One line after reset -> VGA_HS is low while the registered hc is 656..751 (96 pixels); VGA_BLANK_N is high for 640 pixels per visible line.
- Mapper inputs held at 00/FF/FF, pixel at DrawX=0, DrawY=0 sampled -> next pix_en gives VGA_R/G/B = 00/FF/FF, VGA_BLANK_N=1. At DrawX=700 -> outputs 00/00/00, BLANK_N=0.
- Wrap: DrawX=799, DrawY=524, then one pix_en -> DrawX=0, DrawY=0, no frame_tick.
- Reset_n pulsed low at DrawX=300, DrawY=200 -> same cycle: HS=VS=1, BLANK_N=0, RGB=0. After release: DrawX=0, DrawY=0; first increment comes CLK_DIV Clk cycles later.
- With VGA_TEST_PATTERN_EN: DrawX=85 -> RGB 00/00/FF; DrawX=600 -> FF/FF/FF; DrawX=650 -> 00/00/00 (blank).

Source files
------------

// File: rtl/vga_scan_timing_if.sv
// -----------------------------------------------------------------------------
// vga_scan_timing_if
//
// Bundle between the raster scan generator, the colour mapper and the VGA DAC.
//
//   Red_in/Green_in/Blue_in [7:0]  mapper colour for the current DrawX/DrawY
//   DrawX/DrawY             [9:0]  current scan position (includes blanking)
//   VGA_R/VGA_G/VGA_B       [7:0]  registered colour to the DAC
//   VGA_HS, VGA_VS                 active-low syncs
//   VGA_BLANK_N                    low outside the visible region
//   VGA_SYNC_N                     tied low
//   VGA_CLK                        pixel clock
//   frame_tick                     one-clock pulse at the start of vertical blank
//
// Modports:
//   master : the scan timing generator (drives position, DAC and tick)
//   slave  : the mapper / DAC side (drives colour, observes everything else)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface vga_scan_timing_if;
    logic [7:0] Red_in;
    logic [7:0] Green_in;
    logic [7:0] Blue_in;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       frame_tick;

    modport master (
        input  Red_in, Green_in, Blue_in,
        output DrawX, DrawY,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        output frame_tick
    );

    modport slave (
        output Red_in, Green_in, Blue_in,
        input  DrawX, DrawY,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        input  frame_tick
    );
endinterface

// File: rtl/vga_scan_timing.sv
// -----------------------------------------------------------------------------
// vga_scan_timing
//
// Raster scan generator for a VGA DAC. Divides the system clock down to the
// pixel rate, runs the horizontal/vertical counters, exposes them as
// DrawX/DrawY for the colour mapper, and registers the mapper's colour together
// with sync and blank so all DAC-facing signals describe the same pixel in the
// same cycle (one pixel of latency behind DrawX/DrawY).
//
// Ports:
//   Clk      in   system clock (50 MHz)
//   Reset_n  in   asynchronous active-low reset
//   vga      master modport of vga_scan_timing_if (colour in, position,
//            DAC signals and frame_tick out)
//
// Build option:
//   VGA_TEST_PATTERN_EN  when defined, the mapper colour is ignored and the
//                        visible area shows 8 vertical colour bars
//                        (bit0 = blue, bit1 = green, bit2 = red). Sync, blank
//                        and frame_tick timing are unchanged.
//
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_scan_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic              Clk,
    input  logic              Reset_n,
    vga_scan_timing_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START    = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END      = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START    = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END      = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    // Last visible line: wrapping out of it starts vertical blank.
    localparam logic [9:0] V_LAST_VIS  = 10'(V_VISIBLE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       hc_reg;
    logic [9:0]       hc_next;
    logic [9:0]       vc_reg;
    logic [9:0]       vc_next;
    logic             hs_reg;
    logic             vs_reg;
    logic             blank_n_reg;
    logic             vga_clk_reg;
    logic             frame_tick_reg;

    logic             pix_en;
    logic             visible;
    logic             hsync_active;
    logic             vsync_active;
    logic             frame_tick_next;

    logic [2:0][7:0]  color_in;
    logic [2:0][7:0]  color_out;

    // Channel order 0 = red, 1 = green, 2 = blue.
    assign color_in[0] = vga.Red_in;
    assign color_in[1] = vga.Green_in;
    assign color_in[2] = vga.Blue_in;

    // ------------------------------------------------------------------
    // Next-state logic for divider and counters
    // ------------------------------------------------------------------
    always_comb begin
        pix_en          = (div_reg == DIV_LAST);
        div_next        = pix_en ? '0 : div_reg + DIV_W'(1);
        hc_next         = hc_reg;
        vc_next         = vc_reg;
        if (pix_en) begin
            if (hc_reg == H_LAST) begin
                hc_next = '0;
                vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 10'd1;
            end else begin
                hc_next = hc_reg + 10'd1;
            end
        end

        visible         = (hc_reg < H_VIS_END) && (vc_reg < V_VIS_END);
        hsync_active    = (hc_reg >= HS_START) && (hc_reg <= HS_END);
        vsync_active    = (vc_reg >= VS_START) && (vc_reg <= VS_END);
        // Registered, so the pulse lines up with DrawX/DrawY showing (0, V_VISIBLE).
        frame_tick_next = pix_en && (hc_reg == H_LAST) && (vc_reg == V_LAST_VIS);
    end

    // ------------------------------------------------------------------
    // Divider, counters, sync/blank output stage
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_reg        <= '0;
            hc_reg         <= '0;
            vc_reg         <= '0;
            hs_reg         <= 1'b1;
            vs_reg         <= 1'b1;
            blank_n_reg    <= 1'b0;
            vga_clk_reg    <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            div_reg        <= div_next;
            hc_reg         <= hc_next;
            vc_reg         <= vc_next;
            // Registered from div_next so VGA_CLK tracks the divider phase
            // it is shown alongside: high for the first half of each pixel.
            vga_clk_reg    <= (div_next < DIV_HALF);
            frame_tick_reg <= frame_tick_next;
            if (pix_en) begin
                hs_reg      <= !hsync_active;
                vs_reg      <= !vsync_active;
                blank_n_reg <= visible;
            end
        end
    end

    // ------------------------------------------------------------------
    // Colour source
    // ------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);
    logic [2:0] bar_idx;
    assign bar_idx = 3'(hc_reg / BAR_W);
`endif

    // One registered colour channel per generate iteration; blanking forces
    // black so the DAC never sees mapper output outside the visible area.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] src;
            logic [7:0] chan_reg;
`ifdef VGA_TEST_PATTERN_EN
            assign src = {8{bar_idx[2-gi]}};
`else
            assign src = color_in[gi];
`endif
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    chan_reg <= 8'h00;
                end else if (pix_en) begin
                    chan_reg <= visible ? src : 8'h00;
                end
            end
            assign color_out[gi] = chan_reg;
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    // Mapper colour is intentionally unused in pattern mode.
    logic unused_color;
    assign unused_color = ^color_in;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vga.DrawX       = hc_reg;
    assign vga.DrawY       = vc_reg;
    assign vga.VGA_R       = color_out[0];
    assign vga.VGA_G       = color_out[1];
    assign vga.VGA_B       = color_out[2];
    assign vga.VGA_HS      = hs_reg;
    assign vga.VGA_VS      = vs_reg;
    assign vga.VGA_BLANK_N = blank_n_reg;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_CLK     = vga_clk_reg;
    assign vga.frame_tick  = frame_tick_reg;

endmodule

// File: tb/tb_vga_scan_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_timing
//
// Directed bench for vga_scan_timing on a reduced raster (80 x 19 total,
// 64 x 12 visible, CLK_DIV = 4) so whole frames fit in a short run.
// Hand-derived geometry for this raster:
//   hsync low for registered hc 68..75, vsync low for vc 14..15,
//   frame_tick when DrawX/DrawY becomes (0,12), bars 8 pixels wide.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_scan_timing;

    localparam int CLK_DIV   = 4;
    localparam int H_VISIBLE = 64;
    localparam int H_FP      = 4;
    localparam int H_SYNC    = 8;
    localparam int H_BP      = 4;
    localparam int V_VISIBLE = 12;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 3;

    localparam int H_TOTAL   = 80;
    localparam int V_TOTAL   = 19;
    localparam int HS_START  = 68;
    localparam int HS_END    = 75;
    localparam int VS_START  = 14;
    localparam int VS_END    = 15;
`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W     = 8;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    // Bench model of scan position and of the registered DAC outputs.
    int   m_x = 0;
    int   m_y = 0;
    logic [7:0] m_r = 8'h00;
    logic [7:0] m_g = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic m_hs    = 1'b1;
    logic m_vs    = 1'b1;
    logic m_blank = 1'b0;

    // Statistics gathered while scanning.
    int ft_count   = 0;
    int first_ft_x = -1;
    int first_ft_y = -1;
    int vs_low     = 0;
    int hs_low_l0  = 0;
    int hs_lo_min  = 1023;
    int hs_lo_max  = -1;
    int blank_l0   = 0;

    vga_scan_timing_if vif();

    vga_scan_timing #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .vga     (vif)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0;  m_y = 0;
        m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
        m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"},     32'(vif.DrawX),       32'd0);
        check({tag, "_y"},     32'(vif.DrawY),       32'd0);
        check({tag, "_r"},     32'(vif.VGA_R),       32'd0);
        check({tag, "_g"},     32'(vif.VGA_G),       32'd0);
        check({tag, "_b"},     32'(vif.VGA_B),       32'd0);
        check({tag, "_hs"},    32'(vif.VGA_HS),      32'd1);
        check({tag, "_vs"},    32'(vif.VGA_VS),      32'd1);
        check({tag, "_blank"}, 32'(vif.VGA_BLANK_N), 32'd0);
        check({tag, "_tick"},  32'(vif.frame_tick),  32'd0);
        check({tag, "_clk"},   32'(vif.VGA_CLK),     32'd0);
        check({tag, "_syncn"}, 32'(vif.VGA_SYNC_N),  32'd0);
    endtask

    // Advance one pixel period (CLK_DIV clocks) starting just after a pixel
    // boundary, presenting r/g/b at the sampling edge and junk in between.
    task automatic pixel_step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int px, py;
        logic [7:0] er, eg, eb;
        logic vis, hs_act, vs_act, ft_exp;
`ifdef VGA_TEST_PATTERN_EN
        int bar;
`endif
        px = m_x;
        py = m_y;
        check("pos_x", 32'(vif.DrawX), 32'(px));
        check("pos_y", 32'(vif.DrawY), 32'(py));
        vif.Red_in = r; vif.Green_in = g; vif.Blue_in = b;
        for (int k = 0; k < CLK_DIV; k++) begin
            @(posedge clk);
            #1;
            if (k < CLK_DIV - 1) begin
                check("hold_x",     32'(vif.DrawX),      32'(px));
                check("hold_r",     32'(vif.VGA_R),      32'(m_r));
                check("hold_g",     32'(vif.VGA_G),      32'(m_g));
                check("hold_hs",    32'(vif.VGA_HS),     32'(m_hs));
                check("hold_blank", 32'(vif.VGA_BLANK_N),32'(m_blank));
                check("tick_width", 32'(vif.frame_tick), 32'd0);
                check("vga_clk",    32'(vif.VGA_CLK),    32'((k + 1) < (CLK_DIV / 2)));
            end
            if (k == 0) begin
                vif.Red_in = ~r; vif.Green_in = ~g; vif.Blue_in = ~b;
            end
            if (k == 1) begin
                vif.Red_in = r; vif.Green_in = g; vif.Blue_in = b;
            end
        end

        vis    = (px < H_VISIBLE) && (py < V_VISIBLE);
        hs_act = (px >= HS_START) && (px <= HS_END);
        vs_act = (py >= VS_START) && (py <= VS_END);
`ifdef VGA_TEST_PATTERN_EN
        bar = px / BAR_W;
        er = ((bar & 4) != 0) ? 8'hFF : 8'h00;
        eg = ((bar & 2) != 0) ? 8'hFF : 8'h00;
        eb = ((bar & 1) != 0) ? 8'hFF : 8'h00;
`else
        er = r; eg = g; eb = b;
`endif
        if (!vis) begin
            er = 8'h00; eg = 8'h00; eb = 8'h00;
        end

        m_x = px + 1;
        if (m_x == H_TOTAL) begin
            m_x = 0;
            m_y = py + 1;
            if (m_y == V_TOTAL) m_y = 0;
        end
        ft_exp = (m_x == 0) && (m_y == V_VISIBLE);

        check("step_x",    32'(vif.DrawX),       32'(m_x));
        check("step_y",    32'(vif.DrawY),       32'(m_y));
        check("out_r",     32'(vif.VGA_R),       32'(er));
        check("out_g",     32'(vif.VGA_G),       32'(eg));
        check("out_b",     32'(vif.VGA_B),       32'(eb));
        check("out_blank", 32'(vif.VGA_BLANK_N), 32'(vis));
        check("out_hs",    32'(vif.VGA_HS),      32'(!hs_act));
        check("out_vs",    32'(vif.VGA_VS),      32'(!vs_act));
        check("out_tick",  32'(vif.frame_tick),  32'(ft_exp));
        check("clk_pix",   32'(vif.VGA_CLK),     32'd1);
        check("sync_n",    32'(vif.VGA_SYNC_N),  32'd0);

        m_r = er; m_g = eg; m_b = eb;
        m_hs = !hs_act; m_vs = !vs_act; m_blank = vis;

        if (vif.frame_tick) begin
            if (ft_count == 0) begin
                first_ft_x = int'(vif.DrawX);
                first_ft_y = int'(vif.DrawY);
            end
            ft_count++;
        end
        if (!vif.VGA_VS) vs_low++;
        if (ft_count == 0 && py == 0) begin
            if (!vif.VGA_HS) begin
                hs_low_l0++;
                if (px < hs_lo_min) hs_lo_min = px;
                if (px > hs_lo_max) hs_lo_max = px;
            end
            if (vif.VGA_BLANK_N) blank_l0++;
        end
        $display("pixel (%0d,%0d) -> DrawX=%0d DrawY=%0d RGB=%02h/%02h/%02h HS=%0b VS=%0b BLANK_N=%0b tick=%0b",
                 px, py, vif.DrawX, vif.DrawY, vif.VGA_R, vif.VGA_G, vif.VGA_B,
                 vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK_N, vif.frame_tick);
    endtask

    task automatic pixel_step_pat();
        pixel_step(8'(m_x + 3), 8'(m_y * 5 + 1), 8'(m_x ^ (m_y << 2)));
    endtask

    initial begin
        vif.Red_in   = 8'h00;
        vif.Green_in = 8'h00;
        vif.Blue_in  = 8'h00;
        model_reset();

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Release; first pixel with mapper 00/FF/FF at (0,0).
        rst_n = 1'b1;
        pixel_step(8'h00, 8'hFF, 8'hFF);
`ifdef VGA_TEST_PATTERN_EN
        check("first_r", 32'(vif.VGA_R), 32'h00);
        check("first_g", 32'(vif.VGA_G), 32'h00);
        check("first_b", 32'(vif.VGA_B), 32'h00);
`else
        check("first_r", 32'(vif.VGA_R), 32'h00);
        check("first_g", 32'(vif.VGA_G), 32'hFF);
        check("first_b", 32'(vif.VGA_B), 32'hFF);
`endif
        check("first_blank", 32'(vif.VGA_BLANK_N), 32'd1);

        // Two full frames from reset release (first pixel already done).
        for (int n = 1; n < 2 * H_TOTAL * V_TOTAL; n++) pixel_step_pat();
        check("frames_x",      32'(vif.DrawX), 32'd0);
        check("frames_y",      32'(vif.DrawY), 32'd0);
        check("tick_count",    32'(ft_count),  32'd2);
        check("first_tick_x",  32'(first_ft_x), 32'd0);
        check("first_tick_y",  32'(first_ft_y), 32'd12);
        check("vs_low_pixels", 32'(vs_low),    32'd320);
        check("hs_low_count",  32'(hs_low_l0), 32'd8);
        check("hs_low_first",  32'(hs_lo_min), 32'd68);
        check("hs_low_last",   32'(hs_lo_max), 32'd75);
        check("blank_hi_line", 32'(blank_l0),  32'd64);

        // Asynchronous reset mid-frame in the visible area.
        for (int n = 0; n < H_TOTAL * V_TOTAL && !(m_x == 30 && m_y == 5); n++) pixel_step_pat();
        check("mid_x",         32'(vif.DrawX),       32'd30);
        check("mid_y",         32'(vif.DrawY),       32'd5);
        check("mid_blank_pre", 32'(vif.VGA_BLANK_N), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid_hold");
        rst_n = 1'b1;
        pixel_step_pat();
        check("mid_restart_x", 32'(vif.DrawX), 32'd1);

        // Asynchronous reset while both syncs are active.
        for (int n = 0; n < H_TOTAL * V_TOTAL && !(m_x == 71 && m_y == 14); n++) pixel_step_pat();
        check("sync_x",      32'(vif.DrawX),  32'd71);
        check("sync_y",      32'(vif.DrawY),  32'd14);
        check("sync_hs_pre", 32'(vif.VGA_HS), 32'd0);
        check("sync_vs_pre", 32'(vif.VGA_VS), 32'd0);
        #5;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("sync_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pixel_step_pat();
        check("sync_restart_x", 32'(vif.DrawX), 32'd1);
        check("sync_restart_y", 32'(vif.DrawY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
